// File: rtl/serial_sub.sv
// serial_sub: bit-serial A-B subtractor, LSB first; SERIAL_SUB_OVF_EN adds signed overflow flag ovf.
module serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic borrow, d_bit, load, last;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb begin
    load = (state != SHIFT) && start;
    last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    state_nxt = load ? SHIFT : last ? FIN : (state == SHIFT) ? SHIFT : IDLE;
  end
  always_comb begin
    busy  = state == SHIFT;
    done  = state == FIN;
    Bout  = borrow;
    d_bit = a_sh[0] ^ b_sh[0] ^ borrow;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      D      <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      a_sh   <= A;
      b_sh   <= B;
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (busy) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      D      <= {d_bit, D[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      borrow <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
`ifdef SERIAL_SUB_OVF_EN
      // On the last step the shifted-out bits are the operand sign bits.
      if (last) ovf <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
`endif
    end
  end
endmodule
